// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache line reads and posted dcache writebacks onto a single
// memory port. One memory operation is in flight at a time; buffered writes drain before reads.
module mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_req,
  input  logic [WORD_SIZE-1:0] ic_req_addr,
  output logic                 ic_res,
  output logic [WORD_SIZE-1:0] ic_res_addr,
  output logic [LINE_SIZE-1:0] ic_res_data,
  input  logic                 dc_req,
  input  logic [WORD_SIZE-1:0] dc_req_addr,
  output logic                 dc_res,
  output logic [WORD_SIZE-1:0] dc_res_addr,
  output logic [LINE_SIZE-1:0] dc_res_data,
  input  logic                 dc_write,
  input  logic [WORD_SIZE-1:0] dc_write_addr,
  input  logic [LINE_SIZE-1:0] dc_write_data,
  output logic                 dc_wb_full,
  output logic                 wb_overflow,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_req_addr,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_write_addr,
  output logic [LINE_SIZE-1:0] mem_write_data,
  input  logic                 mem_res,
  input  logic [WORD_SIZE-1:0] mem_res_addr,
  input  logic [LINE_SIZE-1:0] mem_res_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_dc_q, owner_dc_d;
  logic                 last_dc_q, last_dc_d;

  logic [WORD_SIZE-1:0] wb_addr_q [2];
  logic [LINE_SIZE-1:0] wb_data_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;

  logic                 mem_req_q, mem_write_q, wb_overflow_q;
  logic [WORD_SIZE-1:0] mem_req_addr_q, mem_write_addr_q;
  logic [LINE_SIZE-1:0] mem_write_data_q;

  logic                 wb_full, push, pop, grant, grant_dc;

  assign wb_full  = (count_q == 2'd2);
  assign push     = dc_write && !wb_full;
  assign pop      = (state_q == ST_IDLE) && (count_q != 2'd0);
  assign grant    = (state_q == ST_IDLE) && (count_q == 2'd0) && (ic_req || dc_req);
  // On a tie, the side that was not granted last wins.
  assign grant_dc = dc_req && (!ic_req || !last_dc_q);

  always_comb begin
    state_d     = state_q;
    owner_dc_d  = owner_dc_q;
    last_dc_d   = last_dc_q;
    ic_res      = 1'b0;
    dc_res      = 1'b0;
    ic_res_addr = mem_res_addr;
    ic_res_data = mem_res_data;
    dc_res_addr = mem_res_addr;
    dc_res_data = mem_res_data;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_dc_d = grant_dc;
          last_dc_d  = grant_dc;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_res) begin
          if (owner_dc_q) dc_res = 1'b1;
          else            ic_res = 1'b1;
          state_d = ST_TURN;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      owner_dc_q       <= 1'b0;
      last_dc_q        <= 1'b0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      count_q          <= 2'd0;
      mem_req_q        <= 1'b0;
      mem_req_addr_q   <= '0;
      mem_write_q      <= 1'b0;
      mem_write_addr_q <= '0;
      mem_write_data_q <= '0;
      wb_overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_dc_q    <= owner_dc_d;
      last_dc_q     <= last_dc_d;
      mem_req_q     <= grant;
      mem_write_q   <= pop;
      wb_overflow_q <= dc_write && wb_full;
      if (grant) mem_req_addr_q <= grant_dc ? dc_req_addr : ic_req_addr;
      if (pop) begin
        mem_write_addr_q <= wb_addr_q[rd_ptr_q];
        mem_write_data_q <= wb_data_q[rd_ptr_q];
        rd_ptr_q         <= ~rd_ptr_q;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      wb_addr_q[wr_ptr_q] <= dc_write_addr;
      wb_data_q[wr_ptr_q] <= dc_write_data;
    end
  end

  assign dc_wb_full     = wb_full;
  assign wb_overflow    = wb_overflow_q;
  assign mem_req        = mem_req_q;
  assign mem_req_addr   = mem_req_addr_q;
  assign mem_write      = mem_write_q;
  assign mem_write_addr = mem_write_addr_q;
  assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory ops and cache responses are queued
// when stimulus is driven and compared as the DUT produces them.
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic         clk, rst;
  logic         ic_req, dc_req, dc_write, mem_res;
  logic [31:0]  ic_req_addr, dc_req_addr, dc_write_addr, mem_res_addr;
  logic [127:0] dc_write_data, mem_res_data;
  logic         ic_res, dc_res, dc_wb_full, wb_overflow, mem_req, mem_write;
  logic [31:0]  ic_res_addr, dc_res_addr, mem_req_addr, mem_write_addr;
  logic [127:0] ic_res_data, dc_res_data, mem_write_data;

  mem_arbiter #(.WORD_SIZE(32), .LINE_SIZE(128)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_req_addr(ic_req_addr),
    .ic_res(ic_res), .ic_res_addr(ic_res_addr), .ic_res_data(ic_res_data),
    .dc_req(dc_req), .dc_req_addr(dc_req_addr),
    .dc_res(dc_res), .dc_res_addr(dc_res_addr), .dc_res_data(dc_res_data),
    .dc_write(dc_write), .dc_write_addr(dc_write_addr), .dc_write_data(dc_write_data),
    .dc_wb_full(dc_wb_full), .wb_overflow(wb_overflow),
    .mem_req(mem_req), .mem_req_addr(mem_req_addr),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_res(mem_res), .mem_res_addr(mem_res_addr), .mem_res_data(mem_res_data)
  );

  typedef struct packed {
    logic         is_write;
    logic [31:0]  addr;
    logic [127:0] data;
  } op_t;

  typedef struct packed {
    logic         is_dc;
    logic [31:0]  addr;
    logic [127:0] data;
  } res_t;

  op_t  exp_ops[$];
  res_t exp_res[$];

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mem_cnt = 0;
  int          inj_cnt = 0;
  int          last_req_cyc = -1;
  logic [31:0] pend_addr = '0;
  logic [31:0] inj_addr = '0;
  logic        prev_req = 1'b0;
  logic        auto_drop = 1'b1;
  logic        spacing_on = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_0000, a + 32'd1, ~a, a ^ 32'h1234_5678};
  endfunction

  function automatic logic [127:0] wdata(input logic [31:0] a);
    return {4{a ^ 32'h0F0F_0F0F}};
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic exp_read(input logic [31:0] a);
    op_t o;
    o.is_write = 1'b0; o.addr = a; o.data = '0;
    exp_ops.push_back(o);
  endtask

  task automatic exp_write(input logic [31:0] a);
    op_t o;
    o.is_write = 1'b1; o.addr = a; o.data = wdata(a);
    exp_ops.push_back(o);
  endtask

  task automatic exp_resp(input logic is_dc, input logic [31:0] a);
    res_t r;
    r.is_dc = is_dc; r.addr = a; r.data = line_of(a);
    exp_res.push_back(r);
  endtask

  // One clock: memory model drives after the edge, outputs are checked on the falling edge.
  task automatic tick();
    op_t  o;
    res_t r;
    @(posedge clk);
    #1;
    cyc++;
    mem_res = 1'b0;
    if (rst) mem_cnt = 0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_res = 1'b1; mem_res_addr = pend_addr; mem_res_data = line_of(pend_addr);
      end
    end
    if (inj_cnt > 0) begin
      inj_cnt--;
      if (inj_cnt == 0) begin
        mem_res = 1'b1; mem_res_addr = inj_addr; mem_res_data = line_of(inj_addr);
      end
    end
    @(negedge clk);
    if (mem_req || mem_write) check("req_wr_excl", 128'(mem_req & mem_write), 128'(0));
    if (mem_req) begin
      check("req_pulse", 128'(prev_req), 128'(0));
      if (exp_ops.size() == 0) check("unexpected_req", 128'(mem_req_addr), 128'('1));
      else begin
        o = exp_ops.pop_front();
        check("op_kind_read", 128'(o.is_write), 128'(0));
        check("req_addr", 128'(mem_req_addr), 128'(o.addr));
      end
      if (spacing_on && last_req_cyc >= 0) check("req_spacing", 128'(cyc - last_req_cyc), 128'(LAT + 3));
      last_req_cyc = cyc;
      mem_cnt = LAT;
      pend_addr = mem_req_addr;
    end
    if (mem_write) begin
      if (exp_ops.size() == 0) check("unexpected_write", 128'(mem_write_addr), 128'('1));
      else begin
        o = exp_ops.pop_front();
        check("op_kind_write", 128'(o.is_write), 128'(1));
        check("write_addr", 128'(mem_write_addr), 128'(o.addr));
        check("write_data", mem_write_data, o.data);
      end
    end
    if (ic_res || dc_res) begin
      check("res_excl", 128'(ic_res & dc_res), 128'(0));
      if (exp_res.size() == 0) check("unexpected_res", 128'({ic_res, dc_res}), 128'(0));
      else begin
        r = exp_res.pop_front();
        check("res_port_dc", 128'(dc_res), 128'(r.is_dc));
        check("res_addr", 128'(dc_res ? dc_res_addr : ic_res_addr), 128'(r.addr));
        check("res_data", dc_res ? dc_res_data : ic_res_data, r.data);
      end
      if (auto_drop) begin
        if (ic_res) ic_req = 1'b0;
        if (dc_res) dc_req = 1'b0;
      end
    end
    prev_req = mem_req;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_ops.size() != 0 || exp_res.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", 128'(exp_ops.size() + exp_res.size()), 128'(0));
    repeat (3) tick();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_mem_req"}, 128'(mem_req), 128'(0));
    check({tag, "_mem_write"}, 128'(mem_write), 128'(0));
    check({tag, "_wb_overflow"}, 128'(wb_overflow), 128'(0));
    check({tag, "_dc_wb_full"}, 128'(dc_wb_full), 128'(0));
    check({tag, "_ic_res"}, 128'(ic_res), 128'(0));
    check({tag, "_dc_res"}, 128'(dc_res), 128'(0));
    check({tag, "_mem_req_addr"}, 128'(mem_req_addr), 128'(0));
    check({tag, "_mem_write_addr"}, 128'(mem_write_addr), 128'(0));
    check({tag, "_mem_write_data"}, mem_write_data, 128'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; mem_res = 1'b0; mem_res_addr = '0; mem_res_data = '0;
    dc_write = 1'b0; dc_write_addr = '0; dc_write_data = '0;
    ic_req = 1'b1; ic_req_addr = 32'h100;
    dc_req = 1'b1; dc_req_addr = 32'h200;
    repeat (2) tick();
    check_reset_outs("reset");

    // Tie from reset: dcache first, then icache.
    exp_read(32'h200); exp_read(32'h100);
    exp_resp(1'b1, 32'h200); exp_resp(1'b0, 32'h100);
    rst = 1'b0;
    wait_done(60);

    // Writeback queued during WAIT must reach memory before the next read.
    dc_req_addr = 32'h300; dc_req = 1'b1;
    exp_read(32'h300); exp_resp(1'b1, 32'h300);
    tick();
    dc_write = 1'b1; dc_write_addr = 32'h40; dc_write_data = wdata(32'h40);
    exp_write(32'h40);
    tick();
    dc_write = 1'b0;
    check("one_entry_full", 128'(dc_wb_full), 128'(0));
    n = 0;
    while (dc_req && n < 50) begin tick(); n++; end
    dc_req_addr = 32'h80; dc_req = 1'b1;
    exp_read(32'h80); exp_resp(1'b1, 32'h80);
    wait_done(60);

    // Three back-to-back writebacks while WAIT: third is dropped.
    ic_req_addr = 32'h500; ic_req = 1'b1;
    exp_read(32'h500); exp_resp(1'b0, 32'h500);
    tick();
    dc_write = 1'b1; dc_write_addr = 32'h600; dc_write_data = wdata(32'h600);
    exp_write(32'h600);
    tick();
    check("full_after_one", 128'(dc_wb_full), 128'(0));
    dc_write_addr = 32'h640; dc_write_data = wdata(32'h640);
    exp_write(32'h640);
    tick();
    check("full_after_two", 128'(dc_wb_full), 128'(1));
    dc_write_addr = 32'h680; dc_write_data = wdata(32'h680);
    tick();
    dc_write = 1'b0;
    check("overflow_pulse", 128'(wb_overflow), 128'(1));
    tick();
    check("overflow_clear", 128'(wb_overflow), 128'(0));
    wait_done(60);
    check("full_drained", 128'(dc_wb_full), 128'(0));

    // Stray memory response while IDLE is ignored.
    inj_addr = 32'h777; inj_cnt = 1;
    tick();
    check("stray_ic_res", 128'(ic_res), 128'(0));
    check("stray_dc_res", 128'(dc_res), 128'(0));
    dc_req_addr = 32'h900; dc_req = 1'b1;
    exp_read(32'h900); exp_resp(1'b1, 32'h900);
    tick();
    check("idle_after_stray", 128'(mem_req), 128'(1));
    wait_done(60);

    // Reset while WAIT abandons the read; writeback in the reset cycle is lost.
    dc_req_addr = 32'hA00; dc_req = 1'b1;
    exp_read(32'hA00);
    tick();
    rst = 1'b1; dc_req = 1'b0;
    dc_write = 1'b1; dc_write_addr = 32'hBAD; dc_write_data = wdata(32'hBAD);
    tick();
    rst = 1'b0; dc_write = 1'b0;
    check_reset_outs("rst_wait");
    inj_addr = 32'hA00; inj_cnt = 2;
    tick();
    tick();
    check_reset_outs("late_res");
    repeat (4) tick();
    check("no_wb_after_rst", 128'(exp_ops.size()), 128'(0));

    // Continuous icache requests: four round trips with fixed spacing.
    auto_drop = 1'b0; spacing_on = 1'b1; last_req_cyc = -1;
    ic_req_addr = 32'hC00; ic_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_read(32'hC00);
      exp_resp(1'b0, 32'hC00);
    end
    n = 0;
    while (exp_res.size() != 0 && n < 100) begin tick(); n++; end
    ic_req = 1'b0;
    wait_done(20);
    spacing_on = 1'b0; auto_drop = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: WORD_SIZE, `WORD_SIZE (32), address width; LINE_SIZE, `CACHE_LINE_SIZE (128), line data width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports (name direction width meaning):
- clk in 1 clock
- rst in 1 sync active-high reset
- ic_req in 1 icache line read request, level, held until ic_res
- ic_req_addr in WORD_SIZE icache read address
- ic_res out 1 icache response valid, 1-cycle pulse
- ic_res_addr out WORD_SIZE / ic_res_data out LINE_SIZE response address/line
- dc_req in 1 dcache line read request, level, held until dc_res
- dc_req_addr in WORD_SIZE dcache read address
- dc_res out 1 dcache response valid, 1-cycle pulse
- dc_res_addr out WORD_SIZE / dc_res_data out LINE_SIZE response address/line
- dc_write in 1 dcache writeback, 1-cycle pulse
- dc_write_addr in WORD_SIZE / dc_write_data in LINE_SIZE writeback address/line
- dc_wb_full out 1 write buffer full
- wb_overflow out 1 writeback dropped, 1-cycle pulse
- mem_req out 1 memory read request, 1-cycle pulse
- mem_req_addr out WORD_SIZE memory read address
- mem_write out 1 memory posted write, 1-cycle pulse
- mem_write_addr out WORD_SIZE / mem_write_data out LINE_SIZE write address/line
- mem_res in 1 memory read response valid
- mem_res_addr in WORD_SIZE / mem_res_data in LINE_SIZE response address/line

Function
REQ-004 FSM states SHALL be IDLE, WAIT, TURN; exactly one memory operation SHALL be in flight at a time.
REQ-005 Write buffer SHALL be a 2-entry FIFO of {addr, line}; dc_wb_full = (count==2), combinational.
REQ-006 dc_write with count<2 SHALL enqueue at the clock edge; dc_write with count==2 SHALL be dropped and assert wb_overflow (registered) the next cycle, even with a simultaneous pop.
REQ-007 In IDLE with count>0, the block SHALL pop the head and drive mem_write=1 with head addr/data (registered) the next cycle; state stays IDLE; back-to-back writes allowed.
REQ-008 Reads SHALL be granted only in IDLE with count==0 (writes have priority; no read bypasses a buffered write).
REQ-009 Read arbitration SHALL be round-robin: if only one requests, grant it; if both, grant the one not granted last; last_owner updates on grant.
REQ-010 On read grant: register mem_req=1 and mem_req_addr=owner address for exactly one cycle, latch owner, state->WAIT.
REQ-011 In WAIT, mem_res SHALL be routed combinationally same cycle: owner IC -> ic_res=1, ic_res_addr/data=mem_res_addr/data; owner DC -> dc_res likewise; state->TURN.
REQ-012 ic_res/dc_res SHALL be 0 unless state==WAIT, mem_res==1, and matching owner; mem_res outside WAIT SHALL be ignored.
REQ-013 TURN SHALL last one cycle with no issue (lets the served requester drop req), then ->IDLE.
REQ-014 Writes enqueued during WAIT/TURN SHALL be drained before the next read grant.
REQ-015 Read latency = 1 cycle (grant to mem_req) + memory latency; minimum gap between consecutive reads = 3 cycles plus memory latency.
REQ-016 mem_req and mem_write SHALL never be high in the same cycle.

Reset
REQ-017 On rst: state=IDLE, count=0, FIFO pointers=0, last_owner=IC (DC wins first tie), mem_req=0, mem_write=0, wb_overflow=0, mem_req_addr=0, mem_write_addr=0, mem_write_data=0.
REQ-018 Reset in WAIT SHALL abandon the transaction; a later mem_res SHALL produce no ic_res/dc_res.
REQ-019 dc_write in the rst cycle SHALL be discarded.

Verification
REQ-020 ic_req=dc_req=1 from reset, addrs 0x100/0x200 -> mem_req addr 0x200 first; mem_res -> dc_res only; after TURN, mem_req addr 0x100.
REQ-021 dc_write 0x40 during WAIT, dc_req 0x80 after dc_res -> mem_write addr 0x40 strictly before mem_req addr 0x80.
REQ-022 Three dc_write pulses in consecutive cycles while WAIT -> dc_wb_full=1 after the second; third dropped, wb_overflow pulse; exactly two mem_writes later.
REQ-023 mem_res while IDLE with ic_req=0, dc_req=0 -> no ic_res/dc_res, state stays IDLE.
REQ-024 rst asserted in WAIT, mem_res 2 cycles later -> no response pulse; all outputs at reset values.
REQ-025 ic_req held continuously, 4 memory round trips of latency 3 -> each mem_req exactly 1 cycle, spacing 6 cycles, never overlapping mem_write.
